wb_scoreboard: RTL and testbench

WB_SCOREBOARD -- requirements
Module: wb_scoreboard

---
 rtl/wb_pkg.sv | 34 +++
 rtl/wb_fifo.sv | 79 +++++++
 rtl/wb_scoreboard.sv | 171 +++++++++++++++++
 tb/tb_wb_scoreboard.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and constants for the writeback scoreboard.
//               REG_ADDR_W / NUM_REGS describe the integer register file.
//               wb_entry_t is the payload buffered for deferred ALU results.
//               reg_onehot() builds a register bitmap mask. Register 0 maps
//               to an empty mask so x0 never takes part in hazard tracking.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    // Width of the buffered result payload. The top-level XLEN is expected
    // to match this value.
    localparam int WB_DATA_W  = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0]  data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (r != '0) begin
            m[r] = 1'b1;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Small circular buffer of wb_entry_t holding ALU results that
//               lost writeback arbitration. Pointers wrap modulo DEPTH.
//               A push while full is dropped, even if a pop happens in the
//               same cycle. A pop while empty is ignored.
// Ports       : i_clk, i_reset (async, active-high)
//               i_push / i_data  - enqueue request and payload
//               i_pop            - dequeue the head entry
//               o_head           - current head entry (valid when !o_empty)
//               o_full, o_empty  - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      i_clk,
    input  logic      i_reset,
    input  logic      i_push,
    input  wb_entry_t i_data,
    input  logic      i_pop,
    output wb_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    // Storage needs no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : wb_scoreboard
// Description : Register scoreboard plus writeback arbiter. It tracks
//               destination registers of issued instructions and stalls
//               issue on RAW/WAW hazards. It merges LSU and ALU results onto
//               a single registered regfile write port. LSU results always
//               win. ALU results that lose arbitration are buffered in
//               wb_fifo. An ALU result falls through directly only when the
//               buffer is empty.
// Config      : WB_BYPASS_EN - when defined, a register being written back
//               this cycle no longer stalls issue. When undefined, issue
//               stalls until the cycle after the write.
// Ports       : i_clk, i_reset (async, active-high)
//               i_issue_*       - decode issue request; o_issue_stall back
//               i_alu_*         - ALU result, handshake with o_alu_ready
//               i_lsu_*         - load result, always accepted
//               o_rd_*          - registered regfile write port
//               o_pending       - scoreboard bitmap, one bit per register
// Revision    : 1.0 - initial release
// ============================================================================
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ALU_FIFO_DEPTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_issue_valid,
    input  logic [REG_ADDR_W-1:0] i_issue_rs1,
    input  logic [REG_ADDR_W-1:0] i_issue_rs2,
    input  logic [REG_ADDR_W-1:0] i_issue_rd,
    output logic                  o_issue_stall,
    input  logic                  i_alu_valid,
    input  logic [REG_ADDR_W-1:0] i_alu_rd,
    input  logic [XLEN-1:0]       i_alu_data,
    output logic                  o_alu_ready,
    input  logic                  i_lsu_valid,
    input  logic [REG_ADDR_W-1:0] i_lsu_rd,
    input  logic [XLEN-1:0]       i_lsu_data,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic [XLEN-1:0]       o_rd_data,
    output logic                  o_rd_wren,
    output logic [NUM_REGS-1:0]   o_pending
);

    logic [NUM_REGS-1:0]   r_pending;
    logic [REG_ADDR_W-1:0] r_rd_addr;
    logic [XLEN-1:0]       r_rd_data;
    logic                  r_rd_wren;

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_fifo_push;
    logic                  w_fifo_pop;
    wb_entry_t             w_fifo_head;
    wb_entry_t             w_alu_entry;
    logic                  w_alu_accept;

    logic                  w_sel_valid;
    logic [REG_ADDR_W-1:0] w_sel_rd;
    logic [XLEN-1:0]       w_sel_data;
    logic                  w_alu_direct;

    logic [NUM_REGS-1:0]   w_clr_mask;
    logic [NUM_REGS-1:0]   w_set_mask;
    logic [NUM_REGS-1:0]   w_busy;
    logic [NUM_REGS-1:0]   w_req_mask;
    logic                  w_issue_accept;

    // ------------------------------------------------------------------
    // Writeback arbitration
    // ------------------------------------------------------------------
    assign o_alu_ready  = !w_fifo_full;
    assign w_alu_accept = i_alu_valid && o_alu_ready;

    assign w_alu_entry.rd   = i_alu_rd;
    assign w_alu_entry.data = WB_DATA_W'(i_alu_data);

    always_comb begin
        w_sel_valid  = 1'b0;
        w_sel_rd     = '0;
        w_sel_data   = '0;
        w_fifo_pop   = 1'b0;
        w_alu_direct = 1'b0;
        if (i_lsu_valid) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = i_lsu_rd;
            w_sel_data  = i_lsu_data;
        end else if (!w_fifo_empty) begin
            w_sel_valid = 1'b1;
            w_fifo_pop  = 1'b1;
            w_sel_rd    = w_fifo_head.rd;
            w_sel_data  = XLEN'(w_fifo_head.data);
        end else if (w_alu_accept) begin
            w_sel_valid  = 1'b1;
            w_alu_direct = 1'b1;
            w_sel_rd     = i_alu_rd;
            w_sel_data   = i_alu_data;
        end
    end

    // An accepted ALU result that did not fall through must be buffered.
    assign w_fifo_push = w_alu_accept && !w_alu_direct;

    wb_fifo #(
        .DEPTH (ALU_FIFO_DEPTH)
    ) u_alu_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_fifo_push),
        .i_data  (w_alu_entry),
        .i_pop   (w_fifo_pop),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Results to x0 are consumed but never write the register file.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd_wren <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
        end else begin
            r_rd_wren <= w_sel_valid && (w_sel_rd != '0);
            if (w_sel_valid) begin
                r_rd_addr <= w_sel_rd;
                r_rd_data <= w_sel_data;
            end
        end
    end

    assign o_rd_wren = r_rd_wren;
    assign o_rd_addr = r_rd_addr;
    assign o_rd_data = r_rd_data;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    assign w_clr_mask = r_rd_wren ? reg_onehot(r_rd_addr) : '0;

`ifdef WB_BYPASS_EN
    // The register written back this cycle is readable from the regfile
    // bypass, so it no longer blocks issue.
    assign w_busy = r_pending & ~w_clr_mask;
`else
    assign w_busy = r_pending;
`endif

    assign w_req_mask = reg_onehot(i_issue_rs1) | reg_onehot(i_issue_rs2)
                      | reg_onehot(i_issue_rd);

    assign o_issue_stall  = i_issue_valid && (|(w_busy & w_req_mask));
    assign w_issue_accept = i_issue_valid && !o_issue_stall;
    assign w_set_mask     = w_issue_accept ? reg_onehot(i_issue_rd) : '0;

    // Set is applied after clear so a same-cycle issue keeps the bit.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_scoreboard
// Description : Directed self-checking bench for wb_scoreboard. The
//               expectations follow the WB_BYPASS_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_scoreboard;
    import wb_pkg::*;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_stall;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_wren;
    logic [31:0] pending;

    int checks = 0;
    int errors = 0;

    wb_scoreboard #(
        .XLEN           (32),
        .ALU_FIFO_DEPTH (2)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_issue_valid (issue_valid),
        .i_issue_rs1   (issue_rs1),
        .i_issue_rs2   (issue_rs2),
        .i_issue_rd    (issue_rd),
        .o_issue_stall (issue_stall),
        .i_alu_valid   (alu_valid),
        .i_alu_rd      (alu_rd),
        .i_alu_data    (alu_data),
        .o_alu_ready   (alu_ready),
        .i_lsu_valid   (lsu_valid),
        .i_lsu_rd      (lsu_rd),
        .i_lsu_data    (lsu_data),
        .o_rd_addr     (rd_addr),
        .o_rd_data     (rd_data),
        .o_rd_wren     (rd_wren),
        .o_pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wb(input string tag, input logic [4:0] addr, input logic [31:0] data);
        check({tag, "_wren"}, 64'(rd_wren), 64'd1);
        check({tag, "_addr"}, 64'(rd_addr), 64'(addr));
        check({tag, "_data"}, 64'(rd_data), 64'(data));
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;

        // ---------------- reset state
        tick(); tick();
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_wren", 64'(rd_wren), 64'd0);
        check("rst_addr", 64'(rd_addr), 64'd0);
        check("rst_data", 64'(rd_data), 64'd0);
        check("rst_ready", 64'(alu_ready), 64'd1);
        rst = 1'b0;

        // ---------------- RAW hazard on x5
        issue_valid = 1'b1; issue_rd = 5'd5; #1;
        check("raw_first_stall", 64'(issue_stall), 64'd0);
        tick();
        check("raw_pending", 64'(pending), 64'h20);
        issue_rd = 5'd0; issue_rs1 = 5'd5; #1;
        check("raw_stall_a", 64'(issue_stall), 64'd1);
        tick();
        check("raw_stall_b", 64'(issue_stall), 64'd1);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_1234; #1;
        check("raw_stall_c", 64'(issue_stall), 64'd1);
        tick();
        alu_valid = 1'b0; #1;
        check_wb("raw_wb", 5'd5, 32'h0000_1234);
`ifdef WB_BYPASS_EN
        check("raw_stall_wb", 64'(issue_stall), 64'd0);
`else
        check("raw_stall_wb", 64'(issue_stall), 64'd1);
`endif
        check("raw_pending_wb", 64'(pending), 64'h20);
        tick();
        check("raw_pending_clr", 64'(pending), 64'd0);
        check("raw_stall_after", 64'(issue_stall), 64'd0);
        check("raw_wren_after", 64'(rd_wren), 64'd0);
        issue_valid = 1'b0; issue_rs1 = 5'd0;

        // ---------------- ALU and LSU in the same cycle
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAAAA_0000;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h1234_5678; #1;
        check("same_ready", 64'(alu_ready), 64'd1);
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        check_wb("same_lsu", 5'd4, 32'h1234_5678);
        tick();
        check_wb("same_alu", 5'd3, 32'hAAAA_0000);
        tick();
        check("same_idle_wren", 64'(rd_wren), 64'd0);
        check("same_idle_addr", 64'(rd_addr), 64'd3);
        check("same_idle_data", 64'(rd_data), 64'hAAAA_0000);

        // ---------------- LSU burst fills the ALU buffer
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h1111_0001;
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'hA1; #1;
        check("fill_ready1", 64'(alu_ready), 64'd1);
        tick();
        check_wb("fill_l1", 5'd9, 32'h1111_0001);
        lsu_rd = 5'd10; lsu_data = 32'h1111_0002;
        alu_rd = 5'd11; alu_data = 32'hA2; #1;
        check("fill_ready2", 64'(alu_ready), 64'd1);
        tick();
        check_wb("fill_l2", 5'd10, 32'h1111_0002);
        lsu_rd = 5'd13; lsu_data = 32'h1111_0003;
        alu_rd = 5'd12; alu_data = 32'hA3; #1;
        check("fill_full3", 64'(alu_ready), 64'd0);
        tick();
        check_wb("fill_l3", 5'd13, 32'h1111_0003);
        lsu_rd = 5'd14; lsu_data = 32'h1111_0004; #1;
        check("fill_full4", 64'(alu_ready), 64'd0);
        tick();
        check_wb("fill_l4", 5'd14, 32'h1111_0004);
        lsu_valid = 1'b0; #1;
        check("drain_full", 64'(alu_ready), 64'd0);
        tick();
        check_wb("drain_a1", 5'd8, 32'hA1);
        check("drain_ready", 64'(alu_ready), 64'd1);
        tick();
        alu_valid = 1'b0;
        check_wb("drain_a2", 5'd11, 32'hA2);
        tick();
        check_wb("drain_a3", 5'd12, 32'hA3);
        tick();
        check("drain_idle", 64'(rd_wren), 64'd0);

        // ---------------- result to x0
        issue_valid = 1'b1; issue_rd = 5'd2;
        tick();
        issue_valid = 1'b0; issue_rd = 5'd0;
        check("x0_pending_pre", 64'(pending), 64'h4);
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF; #1;
        check("x0_ready", 64'(alu_ready), 64'd1);
        tick();
        alu_valid = 1'b0;
        check("x0_wren", 64'(rd_wren), 64'd0);
        check("x0_pending", 64'(pending), 64'h4);
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
        tick();
        alu_valid = 1'b0;
        check_wb("x2_wb", 5'd2, 32'h22);
        tick();
        check("x2_pending_clr", 64'(pending), 64'd0);

        // ---------------- issue rd=7 while x7 commits
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        tick();
        alu_valid = 1'b0;
        check_wb("x7_wb", 5'd7, 32'h77);
        issue_valid = 1'b1; issue_rd = 5'd7; #1;
        check("x7_stall", 64'(issue_stall), 64'd0);
        tick();
        issue_valid = 1'b0; issue_rd = 5'd0;
        check("x7_pending", 64'(pending), 64'h80);
        alu_valid = 1'b1;
        tick();
        alu_valid = 1'b0;
        tick();
        check("x7_pending_clr", 64'(pending), 64'd0);

        // ---------------- reset mid-operation
        issue_valid = 1'b1; issue_rd = 5'd4;
        tick();
        issue_rd = 5'd5;
        tick();
        issue_valid = 1'b0; issue_rd = 5'd0;
        lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'h2020;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h4444;
        tick();
        lsu_rd = 5'd21; lsu_data = 32'h2121;
        alu_rd = 5'd5; alu_data = 32'h5555;
        tick();
        check("mid_pending", 64'(pending), 64'h30);
        check("mid_full", 64'(alu_ready), 64'd0);
        lsu_valid = 1'b0; alu_valid = 1'b0;
        rst = 1'b1; #1;
        check("mid_rst_pending", 64'(pending), 64'd0);
        check("mid_rst_wren", 64'(rd_wren), 64'd0);
        check("mid_rst_addr", 64'(rd_addr), 64'd0);
        check("mid_rst_data", 64'(rd_data), 64'd0);
        tick();
        rst = 1'b0;
        issue_valid = 1'b1; issue_rs1 = 5'd4; #1;
        check("post_rst_ready", 64'(alu_ready), 64'd1);
        check("post_rst_stall", 64'(issue_stall), 64'd0);
        issue_valid = 1'b0; issue_rs1 = 5'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_no_wb", 64'(rd_wren), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
